// File: rtl/lut_vec_pkg.sv
// Shared types and sizes for the vector pair serializer.
// elem_t is one lane element. vec_pair_t packs the a and b vectors of one
// delay-stage output into a single FIFO word.
package lut_vec_pkg;
  localparam int REG_WIDTH = 16;
  localparam int VECTOR    = 4;
  localparam int DEPTH     = 4;
  localparam int LANE_W    = $clog2(VECTOR);
  localparam int PTR_W     = $clog2(DEPTH);
  localparam int LEVEL_W   = PTR_W + 1;

  typedef logic [REG_WIDTH-1:0] elem_t;
  typedef struct packed {
    elem_t [VECTOR-1:0] a;
    elem_t [VECTOR-1:0] b;
  } vec_pair_t;

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(VECTOR - 1);
endpackage

// File: rtl/vector_pair_serializer_fifo.sv
// vec_pair_fifo: synchronous DEPTH-entry FIFO of vec_pair_t words.
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   push      write wdata (ignored when full)
//   wdata     vector pair to store
//   pop       release the head entry (ignored when empty)
//   rdata     head entry, combinational read of registered state
//   full      registered full flag
//   empty     registered empty flag
//   count     registered occupancy, 0..DEPTH
module vec_pair_fifo
  import lut_vec_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  vec_pair_t          wdata,
  input  logic               pop,
  output vec_pair_t          rdata,
  output logic               full,
  output logic               empty,
  output logic [LEVEL_W-1:0] count
);
  vec_pair_t        mem [DEPTH];
  logic [PTR_W:0]   wr_ptr, rd_ptr;
  logic [PTR_W:0]   wr_next, rd_next;
  logic             do_push, do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign wr_next = wr_ptr + (PTR_W+1)'(do_push);
  assign rd_next = rd_ptr + (PTR_W+1)'(do_pop);
  assign rdata   = mem[rd_ptr[PTR_W-1:0]];

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PTR_W-1:0]] <= wdata;
  end

  // Full when the pointers differ only in the wrap bit, empty when equal.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      wr_ptr <= wr_next;
      rd_ptr <= rd_next;
      full   <= (wr_next ^ rd_next) == {1'b1, {PTR_W{1'b0}}};
      empty  <= wr_next == rd_next;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/vector_pair_serializer.sv
// vector_pair_serializer: buffers (a_n, b_n) vector pairs and replays them
// one lane per cycle to a scalar consumer.
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   in_valid / in_ready  vector pair input; in_ready = !full (registered)
//   a_n, b_n             unpacked input vectors, lane 0 first
//   out_valid/out_ready  scalar lane output
//   out_a, out_b         elements of the current lane (0 when idle)
//   out_lane, out_last   current lane index, last-lane flag
//   level                occupied FIFO entries
//   overflow             sticky: a vector was offered while full
// Handshake: a transfer happens on a posedge where valid and ready are both
// high; valid-side payload is held stable while valid is high and ready low.
module vector_pair_serializer
  import lut_vec_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [REG_WIDTH-1:0] a_n [VECTOR],
  input  logic [REG_WIDTH-1:0] b_n [VECTOR],
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [REG_WIDTH-1:0] out_a,
  output logic [REG_WIDTH-1:0] out_b,
  output logic [LANE_W-1:0]    out_lane,
  output logic                 out_last,
  output logic [LEVEL_W-1:0]   level,
  output logic                 overflow
);
  vec_pair_t          wdata, head;
  logic               full, empty, pop;
  logic [LANE_W-1:0]  lane_q;
  logic               lane_step;

  always_comb begin
    wdata = '0;
    for (int i = 0; i < VECTOR; i++) begin
      wdata.a[i] = a_n[i];
      wdata.b[i] = b_n[i];
    end
  end

  vec_pair_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .wdata (wdata),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (level)
  );

  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign lane_step = out_valid & out_ready;
  // The entry leaves the FIFO only once its last lane is accepted.
  assign pop       = lane_step & (lane_q == LAST_LANE);

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q   <= '0;
      overflow <= 1'b0;
    end else begin
      if (lane_step) lane_q <= (lane_q == LAST_LANE) ? '0 : lane_q + 1'b1;
      if (in_valid & ~in_ready) overflow <= 1'b1;
    end
  end

  always_comb begin
    out_a    = '0;
    out_b    = '0;
    out_lane = '0;
    out_last = 1'b0;
    if (out_valid) begin
      out_a    = head.a[lane_q];
      out_b    = head.b[lane_q];
      out_lane = lane_q;
      out_last = lane_q == LAST_LANE;
    end
  end
endmodule

// File: tb/tb_vector_pair_serializer.sv
module tb_vector_pair_serializer;
  typedef logic [40:0] tup_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a_n [4];
  logic [15:0] b_n [4];
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_a, out_b;
  logic [1:0]  out_lane;
  logic        out_last;
  logic [2:0]  level;
  logic        overflow;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  // Reference model: queue of whole vectors plus a lane position.
  logic [63:0] qa [$];
  logic [63:0] qb [$];
  int          lane_m = 0;
  bit          ovf_m = 0;

  vector_pair_serializer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_n(a_n), .b_n(b_n), .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_lane(out_lane), .out_last(out_last),
    .level(level), .overflow(overflow)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  // ---------------- model ----------------
  function automatic tup_t exp_tuple();
    logic        v, lst;
    logic [15:0] ea, eb;
    logic [1:0]  el;
    v = qa.size() > 0;
    ea = '0; eb = '0; el = '0; lst = 1'b0;
    if (v) begin
      ea  = qa[0][16*lane_m +: 16];
      eb  = qb[0][16*lane_m +: 16];
      el  = 2'(lane_m);
      lst = lane_m == 3;
    end
    return {v, ea, eb, el, lst, 3'(qa.size()), qa.size() < 4, ovf_m};
  endfunction

  function automatic tup_t obs_tuple();
    return {out_valid, out_a, out_b, out_lane, out_last, level, in_ready, overflow};
  endfunction

  task automatic model_step(input bit iv, input logic [63:0] a, input logic [63:0] b,
                            input bit ordy, input bit r);
    int sz;
    bit do_pop;
    if (r) begin
      qa.delete(); qb.delete(); lane_m = 0; ovf_m = 0;
      return;
    end
    sz = qa.size();
    do_pop = 0;
    if (sz > 0 && ordy) begin
      if (lane_m == 3) begin lane_m = 0; do_pop = 1; end
      else lane_m++;
    end
    if (do_pop) begin void'(qa.pop_front()); void'(qb.pop_front()); end
    if (iv) begin
      if (sz < 4) begin qa.push_back(a); qb.push_back(b); end
      else ovf_m = 1;
    end
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input bit iv, input logic [63:0] a, input logic [63:0] b,
                       input bit ordy, input bit r);
    @(negedge clk);
    in_valid = iv;
    out_ready = ordy;
    rst = r;
    for (int i = 0; i < 4; i++) begin
      a_n[i] = a[16*i +: 16];
      b_n[i] = b[16*i +: 16];
    end
    @(posedge clk);
    model_step(iv, a, b, ordy, r);
    cyc++;
    #1;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    cycle(0, '0, '0, 0, 1);
    cycle(0, '0, '0, 0, 1);
    tests_run++;
    if (obs_tuple() !== exp_tuple()) begin
      tests_failed++;
      $display("FAIL reset_model cyc %0d: got %h expected %h", cyc, obs_tuple(), exp_tuple());
    end
    tests_run++;
    if ({out_valid, out_a, out_b, out_lane, out_last, level, in_ready, overflow} !== {1'b0, 16'd0, 16'd0, 2'd0, 1'b0, 3'd0, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_const: got v=%b a=%0d b=%0d lane=%0d last=%b lvl=%0d rdy=%b ovf=%b expected 0,0,0,0,0,0,1,0",
               out_valid, out_a, out_b, out_lane, out_last, level, in_ready, overflow);
    end
  endtask

  task automatic test_single();
    logic [63:0] a = {16'd4, 16'd3, 16'd2, 16'd1};
    logic [63:0] b = {16'd40, 16'd30, 16'd20, 16'd10};
    cycle(1, a, b, 1, 0);
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if ({out_valid, out_a, out_b, out_lane, out_last} !== {1'b1, 16'(k+1), 16'(10*(k+1)), 2'(k), k == 3}) begin
        tests_failed++;
        $display("FAIL single_lane%0d: got v=%b a=%0d b=%0d lane=%0d last=%b expected 1,%0d,%0d,%0d,%b",
                 k, out_valid, out_a, out_b, out_lane, out_last, k+1, 10*(k+1), k, k == 3);
      end
      tests_run++;
      if (level !== 3'd1) begin
        tests_failed++;
        $display("FAIL single_level: got %0d expected 1", level);
      end
      cycle(0, '0, '0, 1, 0);
    end
    tests_run++;
    if (obs_tuple() !== exp_tuple() || level !== 3'd0) begin
      tests_failed++;
      $display("FAIL single_drain: got %h expected %h", obs_tuple(), exp_tuple());
    end
  endtask

  task automatic test_overflow();
    logic [63:0] first_a;
    cycle(0, '0, '0, 0, 1);
    for (int k = 0; k < 5; k++) begin
      logic [63:0] a = rnd64();
      if (k == 0) first_a = a;
      cycle(1, a, rnd64(), 0, 0);
      tests_run++;
      if (obs_tuple() !== exp_tuple()) begin
        tests_failed++;
        $display("FAIL fill_%0d: got %h expected %h", k, obs_tuple(), exp_tuple());
      end
    end
    tests_run++;
    if ({overflow, level, in_ready, out_a} !== {1'b1, 3'd4, 1'b0, first_a[15:0]}) begin
      tests_failed++;
      $display("FAIL overflow_const: got ovf=%b lvl=%0d rdy=%b a=%h expected 1,4,0,%h",
               overflow, level, in_ready, out_a, first_a[15:0]);
    end
    for (int k = 0; k < 16; k++) begin
      cycle(0, '0, '0, 1, 0);
      tests_run++;
      if (obs_tuple() !== exp_tuple()) begin
        tests_failed++;
        $display("FAIL ovf_drain cyc %0d: got %h expected %h", cyc, obs_tuple(), exp_tuple());
      end
    end
  endtask

  task automatic test_steady();
    cycle(0, '0, '0, 0, 1);
    for (int k = 0; k < 16; k++) begin
      cycle(k % 4 == 0, rnd64(), rnd64(), 1, 0);
      tests_run++;
      if (obs_tuple() !== exp_tuple() || !out_valid || level > 3'd1 || overflow) begin
        tests_failed++;
        $display("FAIL steady cyc %0d: got %h expected %h", cyc, obs_tuple(), exp_tuple());
      end
    end
  endtask

  task automatic test_stall();
    bit pat [8] = '{1, 0, 0, 1, 1, 0, 1, 1};
    int exp_lane [8] = '{1, 1, 1, 2, 3, 3, 0, 0};
    cycle(0, '0, '0, 0, 1);
    cycle(1, rnd64(), rnd64(), 0, 0);
    for (int k = 0; k < 8; k++) begin
      cycle(0, '0, '0, pat[k], 0);
      tests_run++;
      if (obs_tuple() !== exp_tuple() || (k < 6 && out_lane !== 2'(exp_lane[k]))) begin
        tests_failed++;
        $display("FAIL stall_%0d: got %h lane %0d expected %h lane %0d",
                 k, obs_tuple(), out_lane, exp_tuple(), exp_lane[k]);
      end
    end
  endtask

  task automatic test_full_push_pop();
    cycle(0, '0, '0, 0, 1);
    for (int k = 0; k < 4; k++) cycle(1, rnd64(), rnd64(), 0, 0);
    for (int k = 0; k < 3; k++) cycle(0, '0, '0, 1, 0);
    cycle(1, rnd64(), rnd64(), 1, 0);
    tests_run++;
    if (obs_tuple() !== exp_tuple() || level !== 3'd3 || overflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL full_push_pop: got %h (lvl %0d ovf %b) expected %h (lvl 3 ovf 1)",
               obs_tuple(), level, overflow, exp_tuple());
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] a = rnd64();
    logic [63:0] b = rnd64();
    cycle(0, '0, '0, 0, 1);
    for (int k = 0; k < 3; k++) cycle(1, rnd64(), rnd64(), 0, 0);
    cycle(0, '0, '0, 1, 0);
    cycle(0, '0, '0, 1, 0);
    cycle(0, '0, '0, 0, 1);
    tests_run++;
    if ({level, out_valid, in_ready, overflow} !== {3'd0, 1'b0, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_mid: got lvl=%0d v=%b rdy=%b ovf=%b expected 0,0,1,0",
               level, out_valid, in_ready, overflow);
    end
    cycle(1, a, b, 0, 0);
    tests_run++;
    if ({out_valid, out_lane, out_a, out_b} !== {1'b1, 2'd0, a[15:0], b[15:0]}) begin
      tests_failed++;
      $display("FAIL reset_restart: got v=%b lane=%0d a=%h b=%h expected 1,0,%h,%h",
               out_valid, out_lane, out_a, out_b, a[15:0], b[15:0]);
    end
  endtask

  task automatic test_random();
    cycle(0, '0, '0, 0, 1);
    for (int k = 0; k < 400; k++) begin
      cycle($urandom_range(0, 2) != 0, rnd64(), rnd64(), $urandom_range(0, 3) != 0, 0);
      tests_run++;
      if (obs_tuple() !== exp_tuple()) begin
        tests_failed++;
        $display("FAIL random cyc %0d: got %h expected %h", cyc, obs_tuple(), exp_tuple());
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < 4; i++) begin a_n[i] = '0; b_n[i] = '0; end
    test_reset();
    test_single();
    test_overflow();
    test_steady();
    test_stall();
    test_full_push_pop();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
